// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage and its FIFO.
package cpu_pkg;

    localparam int          CPU_XLEN     = 32;
    localparam int          CPU_ADDR_W   = 16;
    localparam logic [15:0] CPU_RESET_PC = 16'h0000;
    localparam int          PC_INC       = 4;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory and decode handshake bundle seen by the fetch stage.
interface fetch_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]   imem_rdata;
    logic              instr_valid;
    logic [XLEN-1:0]   instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry instruction queue holding {data, pc}; flush empties it in one cycle.
module fetch_fifo #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [PC_W-1:0]   push_pc_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [PC_W-1:0]   head_pc_o
);
    localparam int DEPTH = 2;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;
    logic [DEPTH-1:0]  wr_en;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && !flush_i && (wr_ptr_q == 1'(gi));
        end
    endgenerate

    always_comb begin
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    data_q[i] <= push_data_i;
                    pc_q[i]   <= push_pc_i;
                end
            end
        end
    end

    assign count_o     = count_q;
    assign head_data_o = data_q[rd_ptr_q];
    assign head_pc_o   = pc_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Credit-based instruction fetch with 2-entry queue and redirect flush.
// Optional stall counter output enabled by defining FETCH_STALL_CNT_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                XLEN     = CPU_XLEN,
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    fetch_stage_if.master     fetch_bus
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;
    logic [1:0]        q_count;
    logic [2:0]        occupancy;
    logic              instr_valid, pop, push, credit, issue;
    logic              unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign instr_valid = (q_count != 2'd0);
    assign pop         = instr_valid & fetch_bus.instr_ready;
    // Queued + in-flight entries, minus what decode takes this cycle.
    assign occupancy   = 3'(q_count) + 3'(inflight_q) - 3'(pop);
    assign credit      = (occupancy < 3'd2);
    // A response is only meaningful if its request was issued and not cancelled.
    assign push        = inflight_q & ~redirect_valid;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            FETCH_IDLE: if (prog_start) state_d = FETCH_RUN;
            FETCH_RUN:  issue = prog_start & credit & ~redirect_valid;
            default:    state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FETCH_IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= fetch_pc_q;
        end
    end

    fetch_fifo #(
        .DATA_W (XLEN),
        .PC_W   (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (fetch_bus.imem_rdata),
        .push_pc_i   (inflight_pc_q),
        .pop_i       (pop & ~redirect_valid),
        .count_o     (q_count),
        .head_data_o (fetch_bus.instr),
        .head_pc_o   (fetch_bus.instr_pc)
    );

    assign fetch_bus.imem_req    = issue;
    assign fetch_bus.imem_addr   = fetch_pc_q;
    assign fetch_bus.instr_valid = instr_valid;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (instr_valid && !fetch_bus.instr_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction width.
REQ-002 SHALL have parameter ADDR_W, default 16, byte-address width, matching the 16-bit program counter.
REQ-003 SHALL have parameter RESET_PC, default 16'h0000, first fetch address.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port prog_start  input  1  run enable from the cycle counter stage.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-008 SHALL have port redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored.
REQ-009 SHALL have port imem_req  output  1  instruction memory read strobe.
REQ-010 SHALL have port imem_addr  output  ADDR_W  read byte address, word-aligned.
REQ-011 SHALL have port imem_rdata  input  XLEN  read data, valid exactly 1 cycle after imem_req.
REQ-012 SHALL have port instr_valid  output  1  instruction available to decode.
REQ-013 SHALL have port instr  output  XLEN  instruction word at queue head.
REQ-014 SHALL have port instr_pc  output  ADDR_W  address of instr.
REQ-015 SHALL have port instr_ready  input  1  decode accepts instr.

Function
REQ-016 SHALL implement FSM IDLE -> RUN when prog_start=1; RUN persists until reset; no requests issued in IDLE.
REQ-017 SHALL hold fetch_pc; in RUN with prog_start=1 and credit available, it SHALL assert imem_req with imem_addr=fetch_pc and advance fetch_pc by 4.
REQ-018 SHALL wrap fetch_pc modulo 2^ADDR_W (16'hFFFC -> 16'h0000), without flags.
REQ-019 SHALL define credit as (queue_count + inflight - pop) < 2, where pop = instr_valid & instr_ready in the same cycle.
REQ-020 SHALL capture imem_rdata with its address into a 2-entry FIFO one cycle after the request; the fetch-to-instr_valid latency SHALL be 2 cycles.
REQ-021 SHALL drive instr_valid = (queue_count != 0); instr/instr_pc SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-022 SHALL support simultaneous push and pop at count 1 or 2 without loss; sustained throughput SHALL be 1 instr/cycle with instr_ready=1.
REQ-023 On redirect_valid=1, SHALL flush the FIFO, discard any in-flight response, suppress imem_req that cycle, and load fetch_pc = {redirect_pc[ADDR_W-1:2],2'b00}; redirect SHALL override push, pop and issue.
REQ-024 If prog_start falls in RUN, SHALL stop issuing; in-flight data still lands and drains normally.
REQ-025 SHALL never overflow the FIFO; a push to a full FIFO SHALL be impossible by credit rule.

Reset
REQ-026 While rst_n=0 on a clock edge: state=IDLE, fetch_pc=RESET_PC, queue_count=0, inflight=0, imem_req=0, instr_valid=0, imem_addr=RESET_PC, instr=0, instr_pc=0.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight instructions; the response arriving the cycle after reset SHALL be ignored.

Configuration
REQ-028 With FETCH_STALL_CNT_EN defined, SHALL add output stall_cnt [31:0] counting cycles with instr_valid=1 & instr_ready=0, saturating at 32'hFFFFFFFF, reset to 0.
REQ-029 Without FETCH_STALL_CNT_EN, port stall_cnt and its logic SHALL not exist.

Structure
REQ-030 SHALL take XLEN, ADDR_W default, RESET_PC default, FSM state enum and PC increment constant (4) from shared package cpu_pkg.
REQ-031 SHALL instantiate the 2-entry queue as sub-module fetch_fifo (data+pc, push/pop/flush, count).

Verification
REQ-032 Reset, prog_start=1, instr_ready=1, imem returns addr-as-data -> imem_addr 0,4,8,...; instr_valid first at cycle 2, instr_pc 0,4,8 back-to-back.
REQ-033 instr_ready=0 for 5 cycles -> queue fills to 2, imem_req low, instr held at pc 0; on release, pcs 0,4,8 with no gaps or duplicates.
REQ-034 redirect_valid=1, redirect_pc=16'h0123 while queue full and request in flight -> instr_valid=0 next cycle, next imem_addr=16'h0120, old data never appears.
REQ-035 fetch_pc=16'hFFFC -> next imem_addr=16'h0000, instr_pc sequence FFFC, 0000.
REQ-036 rst_n=0 mid-stream for 1 cycle -> all outputs at reset values, state IDLE; with FETCH_STALL_CNT_EN, 7 stalled cycles -> stall_cnt=7, then 0 after reset.
